// File: rtl/pc_seq_pkg.sv
// pc_seq_pkg: shared state/source enums and XLEN default for the PC sequencing controller
package pc_seq_pkg;
  localparam int XLEN_DEF = 32;
  typedef enum logic [1:0] {BOOT, RUN, WAIT_MEM, PEND} state_t;
  typedef enum logic [1:0] {NONE, EX, ID} src_t;
endpackage

// File: rtl/pc_seq_perf.sv
// pc_seq_perf: redirect and no-progress cycle counters (used under PC_SEQ_PERF_EN)
module pc_seq_perf #(
  parameter int COUNT_W = 32
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               en,
  input  logic               pc_advance,
  input  logic               pc_load,
  output logic [COUNT_W-1:0] redirect_count,
  output logic [COUNT_W-1:0] stall_count
);
  always_ff @(posedge clk) begin
    if (rst) begin
      redirect_count <= '0;
      stall_count    <= '0;
    end else begin
      if (pc_load) redirect_count <= redirect_count + 1'b1;
      if (en && !pc_advance && !pc_load) stall_count <= stall_count + 1'b1;
    end
  end
endmodule

// File: rtl/pc_seq_ctrl.sv
// pc_seq_ctrl: PC hold/advance/redirect and IF/ID, ID/EX stall-flush control; perf counters under PC_SEQ_PERF_EN
module pc_seq_ctrl
  import pc_seq_pkg::*;
#(
  parameter int XLEN = XLEN_DEF
`ifdef PC_SEQ_PERF_EN
  ,
  parameter int COUNT_W = 32
`endif
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               imem_ready,
  input  logic               hazard_stall,
  input  logic               ex_branch_taken,
  input  logic [XLEN-1:0]    ex_branch_target,
  input  logic               id_jump,
  input  logic [XLEN-1:0]    id_jump_target,
  output logic               imem_req,
  output logic               pc_advance,
  output logic               pc_load,
  output logic [XLEN-1:0]    pc_target,
  output logic               stall_if_id,
  output logic               flush_if_id,
  output logic               flush_id_ex
`ifdef PC_SEQ_PERF_EN
  ,
  output logic [COUNT_W-1:0] redirect_count,
  output logic [COUNT_W-1:0] stall_count
`endif
);
  state_t          state;
  src_t            src;
  logic [XLEN-1:0] pend_q;
  logic [XLEN-1:0] sel;
  logic            act;
  logic            run_like;
  logic            redir;
  always_comb begin
    act         = !rst && state != BOOT;
    run_like    = act && (state == RUN || state == WAIT_MEM);
    src         = !act ? NONE : ex_branch_taken ? EX : (id_jump && state != PEND) ? ID : NONE;
    redir       = src != NONE;
    sel         = src == EX ? ex_branch_target : id_jump_target;
    imem_req    = act;
    pc_load     = imem_ready && (state == PEND ? act : run_like && redir);
    pc_advance  = run_like && !redir && !hazard_stall && imem_ready;
    pc_target   = !pc_load ? '0 : (state == PEND && src != EX) ? pend_q : sel;
    stall_if_id = (act && state == PEND) || (run_like && !redir && (hazard_stall || !imem_ready));
    flush_if_id = redir;
    flush_id_ex = src == EX || (run_like && !redir && hazard_stall);
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state  <= BOOT;
      pend_q <= '0;
    end else begin
      state <= state == BOOT ? RUN :
               state == PEND ? (imem_ready ? RUN : PEND) :
               imem_ready    ? RUN : (redir ? PEND : WAIT_MEM);
      if ((run_like && redir && !imem_ready) || (state == PEND && src == EX)) pend_q <= sel;
    end
  end
`ifdef PC_SEQ_PERF_EN
  pc_seq_perf #(.COUNT_W(COUNT_W)) u_perf (
    .clk            (clk),
    .rst            (rst),
    .en             (act),
    .pc_advance     (pc_advance),
    .pc_load        (pc_load),
    .redirect_count (redirect_count),
    .stall_count    (stall_count)
  );
`endif
endmodule

// File: tb/tb_pc_seq_ctrl.sv
// tb_pc_seq_ctrl: directed self-checking bench for pc_seq_ctrl
module tb_pc_seq_ctrl;
  localparam int XLEN = 32;
  logic            clk = 1'b0;
  logic            rst;
  logic            imem_ready;
  logic            hazard_stall;
  logic            ex_branch_taken;
  logic [XLEN-1:0] ex_branch_target;
  logic            id_jump;
  logic [XLEN-1:0] id_jump_target;
  logic            imem_req;
  logic            pc_advance;
  logic            pc_load;
  logic [XLEN-1:0] pc_target;
  logic            stall_if_id;
  logic            flush_if_id;
  logic            flush_id_ex;
`ifdef PC_SEQ_PERF_EN
  logic [31:0]     redirect_count;
  logic [31:0]     stall_count;
`endif
  int checks = 0;
  int errors = 0;
  logic [5:0] obs;
  assign obs = {imem_req, pc_advance, pc_load, stall_if_id, flush_if_id, flush_id_ex};
  always #5 clk = ~clk;
  pc_seq_ctrl #(.XLEN(XLEN)) dut (
    .clk              (clk),
    .rst              (rst),
    .imem_ready       (imem_ready),
    .hazard_stall     (hazard_stall),
    .ex_branch_taken  (ex_branch_taken),
    .ex_branch_target (ex_branch_target),
    .id_jump          (id_jump),
    .id_jump_target   (id_jump_target),
    .imem_req         (imem_req),
    .pc_advance       (pc_advance),
    .pc_load          (pc_load),
    .pc_target        (pc_target),
    .stall_if_id      (stall_if_id),
    .flush_if_id      (flush_if_id),
    .flush_id_ex      (flush_id_ex)
`ifdef PC_SEQ_PERF_EN
    ,
    .redirect_count   (redirect_count),
    .stall_count      (stall_count)
`endif
  );
  task automatic drive(input logic r, input logic rdy, input logic hz, input logic ex,
                       input logic [XLEN-1:0] ext, input logic idj, input logic [XLEN-1:0] idt);
    @(posedge clk);
    #1;
    rst = r; imem_ready = rdy; hazard_stall = hz;
    ex_branch_taken = ex; ex_branch_target = ext;
    id_jump = idj; id_jump_target = idt;
    @(negedge clk);
  endtask
  task automatic test_reset();
    rst = 1; imem_ready = 1; hazard_stall = 0; ex_branch_taken = 0;
    ex_branch_target = 0; id_jump = 0; id_jump_target = 0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    checks++;
    if (obs !== 6'b000000 || pc_target !== 0) begin
      errors++;
      $display("FAIL reset_hold obs=%b tgt=%h exp obs=000000 tgt=0", obs, pc_target);
    end
    drive(0, 1, 0, 0, 0, 0, 0);
    checks++;
    if (obs !== 6'b000000) begin
      errors++;
      $display("FAIL boot obs=%b exp=000000", obs);
    end
`ifdef PC_SEQ_PERF_EN
    checks++;
    if (redirect_count !== 0 || stall_count !== 0) begin
      errors++;
      $display("FAIL reset_counters redir=%0d stall=%0d exp 0 0", redirect_count, stall_count);
    end
`endif
    for (int i = 0; i < 2; i++) begin
      drive(0, 1, 0, 0, 0, 0, 0);
      checks++;
      if (obs !== 6'b110000 || pc_target !== 0) begin
        errors++;
        $display("FAIL run_advance[%0d] obs=%b tgt=%h exp obs=110000 tgt=0", i, obs, pc_target);
      end
    end
  endtask
  task automatic test_branch_priority();
    drive(0, 1, 0, 1, 32'h100, 1, 32'h200);
    checks++;
    if (obs !== 6'b101011 || pc_target !== 32'h100) begin
      errors++;
      $display("FAIL ex_over_id obs=%b tgt=%h exp obs=101011 tgt=00000100", obs, pc_target);
    end
    drive(0, 1, 0, 0, 0, 0, 0);
    checks++;
    if (obs !== 6'b110000) begin
      errors++;
      $display("FAIL after_ex_flush obs=%b exp=110000", obs);
    end
  endtask
  task automatic test_id_jump();
    drive(0, 1, 1, 0, 0, 1, 32'h40);
    checks++;
    if (obs !== 6'b101010 || pc_target !== 32'h40) begin
      errors++;
      $display("FAIL id_jump obs=%b tgt=%h exp obs=101010 tgt=00000040", obs, pc_target);
    end
  endtask
  task automatic test_hazard();
    for (int i = 0; i < 2; i++) begin
      drive(0, 1, 1, 0, 0, 0, 0);
      checks++;
      if (obs !== 6'b100101 || pc_target !== 0) begin
        errors++;
        $display("FAIL hazard[%0d] obs=%b tgt=%h exp obs=100101 tgt=0", i, obs, pc_target);
      end
    end
    drive(0, 1, 0, 0, 0, 0, 0);
    checks++;
    if (obs !== 6'b110000) begin
      errors++;
      $display("FAIL hazard_resume obs=%b exp=110000", obs);
    end
  endtask
  task automatic test_pend();
`ifdef PC_SEQ_PERF_EN
    checks++;
    if (redirect_count !== 2 || stall_count !== 2) begin
      errors++;
      $display("FAIL pre_pend_counters redir=%0d stall=%0d exp 2 2", redirect_count, stall_count);
    end
`endif
    drive(0, 0, 0, 1, 32'h80, 0, 0);
    checks++;
    if (obs !== 6'b100011 || pc_target !== 0) begin
      errors++;
      $display("FAIL pend_entry obs=%b tgt=%h exp obs=100011 tgt=0", obs, pc_target);
    end
    for (int i = 0; i < 2; i++) begin
      drive(0, 0, 0, 0, 0, 1, 32'h999);
      checks++;
      if (obs !== 6'b100100 || pc_target !== 0) begin
        errors++;
        $display("FAIL pend_wait[%0d] obs=%b tgt=%h exp obs=100100 tgt=0", i, obs, pc_target);
      end
    end
    drive(0, 1, 0, 0, 0, 0, 0);
    checks++;
    if (obs !== 6'b101100 || pc_target !== 32'h80) begin
      errors++;
      $display("FAIL pend_load obs=%b tgt=%h exp obs=101100 tgt=00000080", obs, pc_target);
    end
    drive(0, 1, 0, 0, 0, 0, 0);
    checks++;
    if (obs !== 6'b110000) begin
      errors++;
      $display("FAIL pend_exit obs=%b exp=110000", obs);
    end
`ifdef PC_SEQ_PERF_EN
    checks++;
    if (redirect_count !== 3 || stall_count !== 5) begin
      errors++;
      $display("FAIL pend_counters redir=%0d stall=%0d exp 3 5", redirect_count, stall_count);
    end
`endif
  endtask
  task automatic test_wait_mem();
    drive(0, 0, 0, 0, 0, 0, 0);
    checks++;
    if (obs !== 6'b100100) begin
      errors++;
      $display("FAIL run_not_ready obs=%b exp=100100", obs);
    end
    drive(0, 0, 0, 0, 0, 0, 0);
    checks++;
    if (obs !== 6'b100100) begin
      errors++;
      $display("FAIL wait_mem obs=%b exp=100100", obs);
    end
    drive(0, 1, 0, 0, 0, 1, 32'h300);
    checks++;
    if (obs !== 6'b101010 || pc_target !== 32'h300) begin
      errors++;
      $display("FAIL wait_mem_jump obs=%b tgt=%h exp obs=101010 tgt=00000300", obs, pc_target);
    end
    drive(0, 1, 0, 0, 0, 0, 0);
    checks++;
    if (obs !== 6'b110000) begin
      errors++;
      $display("FAIL wait_mem_exit obs=%b exp=110000", obs);
    end
  endtask
  task automatic test_reset_pend();
    drive(0, 0, 0, 1, 32'hC0, 0, 0);
    checks++;
    if (obs !== 6'b100011) begin
      errors++;
      $display("FAIL rp_entry obs=%b exp=100011", obs);
    end
    drive(1, 1, 0, 0, 0, 0, 0);
    checks++;
    if (obs !== 6'b000000 || pc_target !== 0) begin
      errors++;
      $display("FAIL rp_in_reset obs=%b tgt=%h exp obs=000000 tgt=0", obs, pc_target);
    end
    drive(0, 1, 0, 0, 0, 0, 0);
    checks++;
    if (obs !== 6'b000000 || pc_target !== 0) begin
      errors++;
      $display("FAIL rp_boot obs=%b tgt=%h exp obs=000000 tgt=0", obs, pc_target);
    end
    drive(0, 1, 0, 0, 0, 0, 0);
    checks++;
    if (obs !== 6'b110000 || pc_target !== 0) begin
      errors++;
      $display("FAIL rp_no_load obs=%b tgt=%h exp obs=110000 tgt=0", obs, pc_target);
    end
`ifdef PC_SEQ_PERF_EN
    checks++;
    if (redirect_count !== 0 || stall_count !== 0) begin
      errors++;
      $display("FAIL rp_counters redir=%0d stall=%0d exp 0 0", redirect_count, stall_count);
    end
`endif
  endtask
  initial begin
    test_reset();
    test_branch_priority();
    test_id_jump();
    test_hazard();
    test_pend();
    test_wait_mem();
    test_reset_pend();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
